// File: rtl/highscore_table_if.sv
// Submission and result handshake between a game-over producer and the high-score table.
// master drives submissions and observes results; slave is the table itself.
interface highscore_table_if;
    logic        submit_valid;
    logic        submit_ready;
    logic        submit_mode;
    logic [17:0] submit_name;
    logic [15:0] submit_score;
    logic        result_valid;
    logic [1:0]  result_rank;
    logic        result_err;

    modport master (
        output submit_valid, submit_mode, submit_name, submit_score,
        input  submit_ready, result_valid, result_rank, result_err
    );

    modport slave (
        input  submit_valid, submit_mode, submit_name, submit_score,
        output submit_ready, result_valid, result_rank, result_err
    );
endinterface

// File: rtl/highscore_table.sv
// Top-3 high-score store for the classic (lower time wins) and endless (higher points win) tables.
// Optional macro HS_CLEAR_EN adds clear_req/clear_mode to wipe one table while idle.
module highscore_table #(
    parameter logic [5:0]  BLANK_CHAR  = 6'd36,
    parameter logic [15:0] EMPTY_SCORE = 16'h0000
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               display_mode,
`ifdef HS_CLEAR_EN
    input  logic               clear_req,
    input  logic               clear_mode,
`endif
    highscore_table_if.slave   sub,
    output logic [31:0]        name1,
    output logic [31:0]        name2,
    output logic [31:0]        name3,
    output logic [31:0]        score1,
    output logic [31:0]        score2,
    output logic [31:0]        score3,
    output logic [28:0]        metadata
);

    localparam logic [17:0] BLANK_NAME = {3{BLANK_CHAR}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMP0  = 3'd1,
        CMP1  = 3'd2,
        CMP2  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t      state_q, state_d;

    logic        req_mode_q, req_mode_d;
    logic [17:0] req_name_q, req_name_d;
    logic [15:0] req_score_q, req_score_d;
    logic        req_err_q, req_err_d;
    logic [1:0]  rank_q, rank_d;

    logic [2:0]  valid_q [2];
    logic [2:0]  valid_d [2];
    logic [17:0] name_tab_q [2][3];
    logic [17:0] name_tab_d [2][3];
    logic [15:0] score_tab_q [2][3];
    logic [15:0] score_tab_d [2][3];

    logic        disp_mode_q, disp_mode_d;
    logic [17:0] disp_name_q [3];
    logic [17:0] disp_name_d [3];
    logic [15:0] disp_score_q [3];
    logic [15:0] disp_score_d [3];

    logic        accept;
    logic [1:0]  cmp_idx;
    logic [1:0]  slot;

    function automatic logic bcd_bad(input logic [15:0] s);
        return (s[15:12] > 4'd9) || (s[11:8] > 4'd9) ||
               (s[7:4] > 4'd9) || (s[3:0] > 4'd9);
    endfunction

    // An empty slot is beaten by anything; otherwise a tie keeps the existing entry ahead.
    function automatic logic beats(input logic mode, input logic occupied,
                                   input logic [15:0] new_s, input logic [15:0] old_s);
        if (!occupied)
            return 1'b1;
        if (mode)
            return new_s > old_s;
        return new_s < old_s;
    endfunction

    assign accept = (state_q == IDLE) && sub.submit_valid;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sub.submit_valid) state_d = CMP0;
            CMP0:    state_d = CMP1;
            CMP1:    state_d = CMP2;
            CMP2:    state_d = WRITE;
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sub.submit_ready = (state_q == IDLE);
        sub.result_valid = (state_q == DONE);
        sub.result_rank  = (state_q == DONE) ? rank_q : 2'd0;
        sub.result_err   = (state_q == DONE) ? req_err_q : 1'b0;
    end

    always_comb begin
        req_mode_d  = req_mode_q;
        req_name_d  = req_name_q;
        req_score_d = req_score_q;
        req_err_d   = req_err_q;
        rank_d      = rank_q;
        case (state_q)
            CMP1:    cmp_idx = 2'd1;
            CMP2:    cmp_idx = 2'd2;
            default: cmp_idx = 2'd0;
        endcase
        if (accept) begin
            req_mode_d  = sub.submit_mode;
            req_name_d  = sub.submit_name;
            req_score_d = sub.submit_score;
            req_err_d   = bcd_bad(sub.submit_score);
            rank_d      = 2'd0;
        end else if (state_q == CMP0 || state_q == CMP1 || state_q == CMP2) begin
            // Only the first beaten slot sets the rank; later compare steps leave it alone.
            if (!req_err_q && rank_q == 2'd0 &&
                beats(req_mode_q, valid_q[req_mode_q][cmp_idx], req_score_q,
                      score_tab_q[req_mode_q][cmp_idx]))
                rank_d = cmp_idx + 2'd1;
        end
    end

    always_comb begin
        valid_d     = valid_q;
        name_tab_d  = name_tab_q;
        score_tab_d = score_tab_q;
        slot        = 2'd0;
        if (state_q == WRITE && rank_q != 2'd0) begin
            slot = rank_q - 2'd1;
            for (int i = 2; i >= 1; i--) begin
                if (2'(i) > slot) begin
                    name_tab_d[req_mode_q][i]  = name_tab_q[req_mode_q][i-1];
                    score_tab_d[req_mode_q][i] = score_tab_q[req_mode_q][i-1];
                    valid_d[req_mode_q][i]     = valid_q[req_mode_q][i-1];
                end
            end
            name_tab_d[req_mode_q][slot]  = req_name_q;
            score_tab_d[req_mode_q][slot] = req_score_q;
            valid_d[req_mode_q][slot]     = 1'b1;
        end
`ifdef HS_CLEAR_EN
        // A simultaneous submission takes priority over a clear.
        if (state_q == IDLE && !sub.submit_valid && clear_req)
            valid_d[clear_mode] = 3'b000;
`endif
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            req_mode_q  <= 1'b0;
            req_name_q  <= '0;
            req_score_q <= '0;
            req_err_q   <= 1'b0;
            rank_q      <= 2'd0;
            valid_q     <= '{default: 3'b000};
            name_tab_q  <= '{default: '{default: 18'd0}};
            score_tab_q <= '{default: '{default: 16'd0}};
        end else begin
            req_mode_q  <= req_mode_d;
            req_name_q  <= req_name_d;
            req_score_q <= req_score_d;
            req_err_q   <= req_err_d;
            rank_q      <= rank_d;
            valid_q     <= valid_d;
            name_tab_q  <= name_tab_d;
            score_tab_q <= score_tab_d;
        end
    end

    always_comb begin
        disp_mode_d = display_mode;
        for (int i = 0; i < 3; i++) begin
            if (valid_q[display_mode][i]) begin
                disp_name_d[i]  = name_tab_q[display_mode][i];
                disp_score_d[i] = score_tab_q[display_mode][i];
            end else begin
                disp_name_d[i]  = BLANK_NAME;
                disp_score_d[i] = EMPTY_SCORE;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            disp_mode_q  <= 1'b0;
            disp_name_q  <= '{default: BLANK_NAME};
            disp_score_q <= '{default: EMPTY_SCORE};
        end else begin
            disp_mode_q  <= disp_mode_d;
            disp_name_q  <= disp_name_d;
            disp_score_q <= disp_score_d;
        end
    end

    assign name1    = {14'b0, disp_name_q[0]};
    assign name2    = {14'b0, disp_name_q[1]};
    assign name3    = {14'b0, disp_name_q[2]};
    assign score1   = {16'b0, disp_score_q[0]};
    assign score2   = {16'b0, disp_score_q[1]};
    assign score3   = {16'b0, disp_score_q[2]};
    assign metadata = {disp_mode_q, 28'b0};

endmodule

// File: tb/tb_highscore_table.sv
// Scoreboard bench for highscore_table: a sorted-list model predicts ranks and displayed tables,
// and a negedge monitor matches every result pulse against the queued expectation.
module tb_highscore_table;

    localparam logic [31:0] BLANK_NAME32 = 32'h00024924;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        display_mode = 1'b0;
`ifdef HS_CLEAR_EN
    logic        clear_req = 1'b0;
    logic        clear_mode = 1'b0;
`endif
    logic [31:0] name1, name2, name3, score1, score2, score3;
    logic [28:0] metadata;

    highscore_table_if sif();

    highscore_table dut (
        .clock        (clock),
        .resetn       (resetn),
        .display_mode (display_mode),
`ifdef HS_CLEAR_EN
        .clear_req    (clear_req),
        .clear_mode   (clear_mode),
`endif
        .sub          (sif),
        .name1        (name1),
        .name2        (name2),
        .name3        (name3),
        .score1       (score1),
        .score2       (score2),
        .score3       (score3),
        .metadata     (metadata)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] rank;
        logic       err;
        int         acc;
    } exp_t;

    exp_t exp_q[$];

    // Each table is a best-first list of up to three (name, score) entries.
    int          m_cnt [2];
    logic [15:0] m_score [2][3];
    logic [17:0] m_name [2][3];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", nm, act, expv);
        end
    endtask

    function automatic logic isBetter(input logic mode, input logic [15:0] a, input logic [15:0] b);
        return mode ? (a > b) : (a < b);
    endfunction

    task automatic modelClear();
        m_cnt[0] = 0;
        m_cnt[1] = 0;
    endtask

    task automatic modelSubmit(input logic mode, input logic [17:0] nm, input logic [15:0] sc,
                               output logic [1:0] rank, output logic err);
        int pos;
        err  = 1'b0;
        rank = 2'd0;
        for (int d = 0; d < 4; d++)
            if (sc[d*4 +: 4] > 4'd9) err = 1'b1;
        if (err) return;
        pos = 0;
        for (int i = 0; i < m_cnt[mode]; i++)
            if (!isBetter(mode, sc, m_score[mode][i])) pos++;
        if (pos >= 3) return;
        rank = 2'(pos + 1);
        for (int i = 2; i > pos; i--) begin
            m_score[mode][i] = m_score[mode][i-1];
            m_name[mode][i]  = m_name[mode][i-1];
        end
        m_score[mode][pos] = sc;
        m_name[mode][pos]  = nm;
        if (m_cnt[mode] < 3) m_cnt[mode]++;
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (sif.result_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_result: got rank %0d err %0b, expected no pulse",
                         sif.result_rank, sif.result_err);
            end else begin
                e = exp_q.pop_front();
                check("result_rank", 32'(sif.result_rank), 32'(e.rank));
                check("result_err", 32'(sif.result_err), 32'(e.err));
                check("result_latency", 32'(cyc - e.acc), 32'd5);
            end
        end
    end

    task automatic checkOutput();
        logic        m;
        logic [31:0] act_n, act_s, exp_n, exp_s;
        repeat (2) @(negedge clock);
        m = display_mode;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       begin act_n = name1; act_s = score1; end
                1:       begin act_n = name2; act_s = score2; end
                default: begin act_n = name3; act_s = score3; end
            endcase
            exp_n = (i < m_cnt[m]) ? {14'b0, m_name[m][i]} : BLANK_NAME32;
            exp_s = (i < m_cnt[m]) ? {16'b0, m_score[m][i]} : 32'h0;
            check($sformatf("name%0d_mode%0d", i + 1, m), act_n, exp_n);
            check($sformatf("score%0d_mode%0d", i + 1, m), act_s, exp_s);
        end
        check("metadata", 32'(metadata), {3'b0, m, 28'b0});
    endtask

    task automatic applyStimulus(input logic mode, input logic [17:0] nm, input logic [15:0] sc,
                                 input logic disp_mid);
        int   n;
        exp_t e;
        @(negedge clock);
        n = 0;
        while (!sif.submit_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!sif.submit_ready) begin
            tests++;
            fails++;
            $display("[TB] FAIL ready_timeout: got ready 0, expected 1");
            return;
        end
        modelSubmit(mode, nm, sc, e.rank, e.err);
        e.acc = cyc;
        exp_q.push_back(e);
        sif.submit_valid = 1'b1;
        sif.submit_mode  = mode;
        sif.submit_name  = nm;
        sif.submit_score = sc;
        @(negedge clock);
        check("ready_drop", 32'(sif.submit_ready), 32'd0);
        sif.submit_valid = 1'b0;
        sif.submit_mode  = 1'($urandom);
        sif.submit_name  = 18'($urandom);
        sif.submit_score = 16'($urandom);
`ifdef HS_CLEAR_EN
        clear_req = 1'b0;
`endif
        display_mode = disp_mid;
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL result_timeout: got %0d pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] sc;
        logic        md;
        sif.submit_valid = 1'b0;
        sif.submit_mode  = 1'b0;
        sif.submit_name  = '0;
        sif.submit_score = '0;
        modelClear();

        resetn = 1'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        check("ready_after_reset", 32'(sif.submit_ready), 32'd1);
        check("rv_after_reset", 32'(sif.result_valid), 32'd0);
        check("name1_blank_const", name1, BLANK_NAME32);
        checkOutput();

        // Endless table: 0500, 0900, 0700 -> ranks 1, 1, 2
        display_mode = 1'b1;
        applyStimulus(1'b1, 18'h00001, 16'h0500, 1'b1);
        applyStimulus(1'b1, 18'h00002, 16'h0900, 1'b1);
        applyStimulus(1'b1, 18'h00003, 16'h0700, 1'b1);
        checkOutput();
        check("endless_score1_const", score1, 32'h0900);
        check("endless_score3_const", score3, 32'h0500);

        // Classic table: fill, tie on 0200 loses, 0300 does not place
        display_mode = 1'b0;
        applyStimulus(1'b0, 18'h0000A, 16'h0245, 1'b0);
        applyStimulus(1'b0, 18'h0000B, 16'h0130, 1'b0);
        applyStimulus(1'b0, 18'h0000C, 16'h0200, 1'b0);
        applyStimulus(1'b0, 18'h0000D, 16'h0200, 1'b0);
        checkOutput();
        check("classic_tie_name3_const", name3, 32'h0000D);
        applyStimulus(1'b0, 18'h0000E, 16'h0300, 1'b0);
        checkOutput();

        // Invalid BCD leaves both tables alone
        applyStimulus(1'b0, 18'h0000F, 16'h01A5, 1'b1);
        checkOutput();
        display_mode = 1'b0;
        checkOutput();

        // Reset during CMP1 drops the request
        @(negedge clock);
        sif.submit_valid = 1'b1;
        sif.submit_mode  = 1'b1;
        sif.submit_name  = 18'h00123;
        sif.submit_score = 16'h0100;
        @(negedge clock);
        sif.submit_valid = 1'b0;
        @(posedge clock);
        #2 resetn = 1'b0;
        modelClear();
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        check("ready_after_midreset", 32'(sif.submit_ready), 32'd1);
        checkOutput();
        display_mode = 1'b1;
        checkOutput();

`ifdef HS_CLEAR_EN
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 18'(16 + i), 16'(16'h0100 * (i + 1)), 1'b0);
            applyStimulus(1'b1, 18'(32 + i), 16'(16'h0100 * (i + 1)), 1'b1);
        end
        @(negedge clock);
        clear_mode = 1'b1;
        clear_req  = 1'b1;
        @(negedge clock);
        clear_req  = 1'b0;
        m_cnt[1]   = 0;
        display_mode = 1'b1;
        checkOutput();
        display_mode = 1'b0;
        checkOutput();
        clear_mode = 1'b0;
        clear_req  = 1'b1;
        applyStimulus(1'b0, 18'h00777, 16'h0050, 1'b0);
        checkOutput();
`endif

        // Randomized traffic with narrow score range so ties and full tables occur
        for (int k = 0; k < 40; k++) begin
            md = 1'($urandom);
            sc = {4'h0, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 9)), 4'h0};
            if ($urandom_range(0, 9) == 0)
                sc[$urandom_range(0, 3) * 4 +: 4] = 4'($urandom_range(10, 15));
            applyStimulus(md, 18'($urandom), sc, 1'($urandom));
            if (k % 4 == 3) checkOutput();
        end
        checkOutput();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/highscore_table.md
Name: highscore_table

Overview:
- Sequential store feeding the high-score screen address processor.
- Holds top-3 name/score entries for each game type: classic (time, lower is better) and endless (points, higher is better).
- Accepts a finished-game result over a valid/ready handshake, ranks it, inserts it, and reports the rank.
- Drives name1..3, score1..3 and the gameType metadata bit consumed by the display stage.

Parameters:
- BLANK_CHAR, 6'd36, character code shown for each char of an empty slot.
- EMPTY_SCORE, 16'h0000, BCD score shown for an empty slot.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- display_mode  in  1  table shown: 0 classic, 1 endless.
- submit_valid  in  1  result offered.
- submit_ready  out  1  block can accept a result.
- submit_mode  in  1  table targeted: 0 classic, 1 endless.
- submit_name  in  18  three 6-bit char codes, [17:12] leftmost.
- submit_score  in  16  4 BCD digits, [15:12] most significant; classic = mm:ss.
- result_valid  out  1  one-cycle pulse, ranking done.
- result_rank  out  2  0 = not placed or rejected, 1..3 = slot taken.
- result_err  out  1  submission rejected as invalid BCD; valid with result_valid.
- name1, name2, name3  out  32  {14'b0, 18-bit name} of ranks 1..3 of the displayed table.
- score1, score2, score3  out  32  {16'b0, 16-bit BCD score}.
- metadata  out  29  bit 28 = registered display_mode; [27:0] = 0.

Behaviour:
- Reset (async, resetn=0):
  - All 6 entries invalid.
  - FSM to IDLE, submit_ready=1, result_valid=0, result_rank=0, result_err=0.
  - nameN = {14'b0, {3{BLANK_CHAR}}}, scoreN = {16'b0, EMPTY_SCORE}, metadata=0.
  - Any in-flight request is dropped with no result pulse.
- Handshake:
  - A request is accepted on a rising edge with submit_valid && submit_ready.
  - mode, name and score are latched on that edge.
  - submit_ready=1 only in IDLE; it drops the cycle after acceptance.
- FSM: IDLE -> CMP0 -> CMP1 -> CMP2 -> WRITE -> DONE -> IDLE. Fixed path, no early exit.
  - CMPk (k = 0..2): the latched score beats entry k if entry k is invalid, or if (classic: new < entry) or (endless: new > entry).
  - Comparison is unsigned on the 16-bit BCD.
  - Rank = 1 + index of the first entry beaten; rank 0 if none is beaten.
  - Ties: the existing entry wins; the new entry ranks below it.
  - WRITE, rank r != 0: entries from slot r-1 downward shift down one slot, the old slot 3 is discarded, and the new entry is written valid at slot r-1. Rank 0: no write.
  - DONE: result_valid=1 for exactly one cycle with rank/err; submit_ready returns to 1 the next cycle.
- Latency: result_valid is high in the 5th cycle after the acceptance edge.
- Invalid BCD: any nibble of submit_score > 9 gives rank 0, result_err=1, and no table change. The FSM still runs the full path.
- Only the table selected by submit_mode is touched; the other table is never modified.
- Display outputs:
  - Registered; they reflect the table selected by display_mode one cycle after any write or display_mode change.
  - Invalid slots show the blank name and EMPTY_SCORE.
- display_mode changing mid-insert: allowed; it has no effect on the insert.
- submit_valid deasserted while busy: ignored. Inputs are don't-care outside the acceptance edge.

Optional Feature:
- Macro HS_CLEAR_EN.
- Defined:
  - Adds port clear_req (in, 1) and clear_mode (in, 1).
  - clear_req sampled high in IDLE with submit_valid low invalidates all 3 entries of the clear_mode table on that edge; display updates the next cycle.
  - In IDLE with submit_valid and clear_req both high, the submission wins and the clear is ignored.
  - clear_req outside IDLE is ignored.
- Undefined: no ports; the tables are cleared only by reset.

Test Plan:
- Reset then idle, display_mode=0 -> name1..3 = 32'h00024924 (BLANK_CHAR 36 ×3), score1..3 = 0, submit_ready=1, no result_valid.
- Endless submissions 16'h0500, then 16'h0900, then 16'h0700, display_mode=1 -> ranks 1,1,2; score1=0x0900, score2=0x0700, score3=0x0500; each result_valid exactly 5 cycles after acceptance.
- Classic table full at {0x0130, 0x0200, 0x0245}, submit 0x0200 -> rank 3, score3=0x0200 (tie loses to existing); then submit 0x0300 -> rank 0, table unchanged.
- Submit score 16'h01A5 -> result_rank=0, result_err=1, both tables unchanged.
- Accept a submission, pull resetn low at CMP1, release -> no result_valid, all entries blank, submit_ready=1 one cycle after release.
- With HS_CLEAR_EN: fill both tables, pulse clear_req with clear_mode=1 -> endless table blank, classic entries intact; repeat with submit_valid also high -> submission processed, no clear.
